// File: rtl/param_universal_shift_reg.sv
// param_universal_shift_reg
//
// WIDTH-bit universal register. It supports parallel load, single-step shift or rotate,
// and a burst engine that shifts N positions at one position per clock.
//
// Parameters:
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value held in out after reset
//   CW         (local) width of shift_cnt, $clog2(WIDTH)+1
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         parallel load data
//   load       parallel load request (idle only)
//   mode       00 shr (ser_in->MSB), 01 shl (ser_in->LSB), 10 rotr, 11 rotl
//   ser_in     serial fill bit for the shift modes, sampled live every cycle
//   step       single shift request (idle only)
//   start      burst request (idle only); captures mode and shift_cnt
//   shift_cnt  burst length N
//   out        register contents
//   ser_out    last bit ejected by a shift or rotate (registered)
//   busy       burst in progress
//   done       one-cycle pulse when a burst completes (or on start with N = 0)
//   parity     (USR_PARITY_EN only) registered XOR of out
//
// Optional feature macro: USR_PARITY_EN adds the parity output and its register.
// When the macro is left undefined, the block has no parity port and no parity logic.

module param_universal_shift_reg #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0,
  localparam int unsigned           CW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             step,
  input  logic             start,
  input  logic [CW-1:0]    shift_cnt,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ser_out_q, ser_out_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  // The result is packed as {ejected bit, new register value}.
  function automatic logic [WIDTH:0] shift_op(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       m,
                                              input logic             s);
    logic [WIDTH:0] r;
    unique case (m)
      2'b00:   r = {v[0],       s,          v[WIDTH-1:1]};
      2'b01:   r = {v[WIDTH-1], v[WIDTH-2:0], s};
      2'b10:   r = {v[0],       v[0],       v[WIDTH-1:1]};
      default: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
    endcase
    return r;
  endfunction

  // A burst with N = 0 never enters StShift; it only raises done.
  logic burst_go;
  assign burst_go = !load && start && (shift_cnt != '0);

  logic last_shift;
  assign last_shift = (cnt_q == CW'(1));

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (burst_go) state_d = StShift;
      StShift: if (last_shift) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath next-state logic
  //--------------------------------------------------------------------------
  logic [WIDTH:0] step_res;
  logic [WIDTH:0] burst_res;

  assign step_res  = shift_op(out_q, mode, ser_in);
  assign burst_res = shift_op(out_q, mode_q, ser_in);

  always_comb begin
    out_d     = out_q;
    ser_out_d = ser_out_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          out_d = in;
        end else if (start) begin
          if (shift_cnt != '0) begin
            mode_d = mode;
            cnt_d  = shift_cnt;
          end else begin
            done_d = 1'b1;
          end
        end else if (step) begin
          out_d     = step_res[WIDTH-1:0];
          ser_out_d = step_res[WIDTH];
        end
      end
      StShift: begin
        // The live mode input is ignored here; only the captured mode is used.
        out_d     = burst_res[WIDTH-1:0];
        ser_out_d = burst_res[WIDTH];
        cnt_d     = cnt_q - CW'(1);
        if (last_shift) begin
          done_d = 1'b1;
        end
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= RESET_VAL;
      ser_out_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
    end else begin
      out_q     <= out_d;
      ser_out_q <= ser_out_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
    end
  end

`ifdef USR_PARITY_EN
  logic parity_q;

  // Computed from out_d so that parity changes on the same edge as out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= ^RESET_VAL;
    end else begin
      parity_q <= ^out_d;
    end
  end
`endif

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    out     = out_q;
    ser_out = ser_out_q;
    done    = done_q;
    busy    = (state_q == StShift);
`ifdef USR_PARITY_EN
    parity  = parity_q;
`endif
  end

endmodule

// File: tb/tb_param_universal_shift_reg.sv
module tb_param_universal_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in;
  logic          load, ser_in, step, start;
  logic [1:0]    mode;
  logic [CW-1:0] shift_cnt;
  logic [W-1:0]  out;
  logic          ser_out, busy, done;
`ifdef USR_PARITY_EN
  logic          parity;
`endif

  param_universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .mode      (mode),
    .ser_in    (ser_in),
    .step      (step),
    .start     (start),
    .shift_cnt (shift_cnt),
    .out       (out),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
`ifdef USR_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic         ser;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: the register is held as a value, and a burst is represented
  // as a queue of pending single shifts.
  logic [W-1:0] m_out;
  logic         m_ser;
  logic         m_done;
  logic [1:0]   m_pend[$];

  function automatic void apply(input logic [1:0] md, input logic s);
    logic [W-1:0] v;
    v = m_out;
    case (md)
      2'b00: begin m_ser = v[0];   m_out = (v >> 1) | ({7'b0, s} << 7); end
      2'b01: begin m_ser = v[W-1]; m_out = (v << 1) | {7'b0, s};        end
      2'b10: begin m_ser = v[0];   m_out = (v >> 1) | ({7'b0, v[0]} << 7); end
      default: begin m_ser = v[W-1]; m_out = (v << 1) | {7'b0, v[W-1]}; end
    endcase
  endfunction

  function automatic void model_reset();
    m_out  = 8'h00;
    m_ser  = 1'b0;
    m_done = 1'b0;
    m_pend.delete();
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock: drive the inputs at the falling edge, predict the result of the next
  // rising edge, then return shortly after that edge once the monitor has run.
  task automatic tick(input logic ld, input logic st, input logic stp, input logic [W-1:0] d,
                      input logic [1:0] md, input logic s, input logic [CW-1:0] n);
    exp_t e;
    @(negedge clk);
    load = ld; start = st; step = stp; in = d; mode = md; ser_in = s; shift_cnt = n;
    m_done = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_pend.size() > 0) begin
      apply(m_pend.pop_front(), s);
      if (m_pend.size() == 0) m_done = 1'b1;
    end else if (ld) begin
      m_out = d;
    end else if (st) begin
      if (n == 0) m_done = 1'b1;
      else for (int i = 0; i < int'(n); i++) m_pend.push_back(md);
    end else if (stp) begin
      apply(md, s);
    end
    e.out  = m_out;
    e.ser  = m_ser;
    e.busy = (m_pend.size() > 0);
    e.done = m_done;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, '0);
  endtask

  // Monitor: each rising edge the DUT presents a new output word.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("out",     32'(out),     32'(e.out));
      chk("ser_out", 32'(ser_out), 32'(e.ser));
      chk("busy",    32'(busy),    32'(e.busy));
      chk("done",    32'(done),    32'(e.done));
`ifdef USR_PARITY_EN
      chk("parity",  32'(parity),  32'(^e.out));
`endif
    end
  end

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out",  32'(out),  32'h00);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    idle();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load = 0; start = 0; step = 0; in = '0; mode = '0; ser_in = 0;
    shift_cnt = '0;
    model_reset();
    #3;
    chk("reset_out",  32'(out),     32'h00);
    chk("reset_ser",  32'(ser_out), 32'h0);
    chk("reset_busy", 32'(busy),    32'h0);
    idle();
    #1 rst_n = 1'b1;
    idle();

    // Load, then an asynchronous reset without a clock edge.
    tick(1, 0, 0, 8'hA5, 2'b00, 0, '0);
    chk("load_a5", 32'(out), 32'hA5);
    async_reset();

    // Single steps.
    tick(1, 0, 0, 8'hA5, 2'b00, 0, '0);
    tick(0, 0, 1, 8'h00, 2'b00, 1, '0);
    chk("step_shr", 32'(out), 32'hD2);
    chk("step_shr_ser", 32'(ser_out), 32'h1);
    tick(0, 0, 1, 8'h00, 2'b01, 0, '0);
    chk("step_shl", 32'(out), 32'hA4);
    chk("step_shl_ser", 32'(ser_out), 32'h1);

    // Rotate-right burst of 3 while the mode input toggles.
    tick(1, 0, 0, 8'h81, 2'b00, 0, '0);
    tick(0, 1, 0, 8'h00, 2'b10, 0, 4'd3);
    chk("rotr_busy0", 32'(busy), 32'h1);
    tick(0, 0, 0, 8'h00, 2'b01, 1, '0);
    chk("rotr_1", 32'(out), 32'hC0);
    tick(0, 0, 0, 8'h00, 2'b11, 1, '0);
    chk("rotr_2", 32'(out), 32'h60);
    tick(0, 0, 0, 8'h00, 2'b00, 1, '0);
    chk("rotr_3", 32'(out), 32'h30);
    chk("rotr_done", 32'(done), 32'h1);
    idle();
    chk("rotr_done_pulse", 32'(done), 32'h0);

    // Rotate-left burst of WIDTH with load/step ignored while busy.
    tick(1, 0, 0, 8'h3C, 2'b00, 0, '0);
    tick(0, 1, 0, 8'h00, 2'b11, 0, 4'd8);
    for (int i = 0; i < 8; i++) tick(1, 0, 1, 8'hFF, 2'b00, 1, '0);
    chk("rotl8_out", 32'(out), 32'h3C);
    chk("rotl8_done", 32'(done), 32'h1);

    // Zero-length burst, then load beating start.
    tick(0, 1, 0, 8'h00, 2'b00, 0, 4'd0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_out",  32'(out),  32'h3C);
    tick(1, 1, 0, 8'h5A, 2'b00, 0, 4'd4);
    chk("load_wins_out",  32'(out),  32'h5A);
    chk("load_wins_busy", 32'(busy), 32'h0);

    // Reset in the middle of a burst, then a fresh burst.
    tick(0, 1, 0, 8'h00, 2'b00, 1, 4'd5);
    idle();
    idle();
    async_reset();
    chk("abort_no_done", 32'(done), 32'h0);
    tick(1, 0, 0, 8'h96, 2'b00, 0, '0);
    tick(0, 1, 0, 8'h00, 2'b01, 0, 4'd2);
    idle();
    idle();
    chk("fresh_done", 32'(done), 32'h1);
    chk("fresh_out",  32'(out),  32'h58);

    // Shift burst longer than the width: filled with ser_in.
    tick(0, 1, 0, 8'h00, 2'b00, 0, 4'd11);
    for (int i = 0; i < 11; i++) tick(0, 0, 0, 8'h00, 2'b10, 1, '0);
    chk("fill_out", 32'(out), 32'hFF);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 8) == 0, ($urandom % 5) == 0, $urandom % 2, W'($urandom),
           2'($urandom), 1'($urandom), CW'($urandom % 16));
    end

    repeat (3) idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/param_universal_shift_reg.md
Name: param_universal_shift_reg

Overview:
- Parametrised successor to the 4-bit PIPO register: WIDTH-bit register with parallel load, single-step shift/rotate and a multi-cycle burst-shift engine.
- Used as a data holding and serialising stage between datapath blocks; SER_IN/SER_OUT allow cascading.
- Burst FSM shifts the register N positions, one per clock, and reports Busy/Done.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VAL, 0, value loaded into OUT on reset (WIDTH bits).
- CW (localparam, not overridable), $clog2(WIDTH)+1, width of Shift_Cnt.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN  input  WIDTH  parallel load data.
- Load  input  1  parallel load request.
- MODE  input  2  shift operation. 00 = shift right (SER_IN→MSB). 01 = shift left (SER_IN→LSB). 10 = rotate right. 11 = rotate left.
- SER_IN  input  1  serial fill bit for modes 00/01.
- Step  input  1  single shift request.
- Start  input  1  burst shift request.
- Shift_Cnt  input  CW  burst length N, 0..2^CW-1.
- OUT  output  WIDTH  register contents.
- SER_OUT  output  1  last bit shifted or rotated out (registered).
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, RST_N=0): OUT=RESET_VAL, SER_OUT=0, Busy=0, Done=0, FSM=IDLE, count=0, captured mode=00. Takes effect immediately, including mid-burst; the burst is abandoned with no Done.
- All other updates occur on the rising edge of CLK; outputs are valid the cycle after the sampling edge.
- FSM states: IDLE and SHIFT.
- IDLE priority: Load > Start > Step. Only one action per cycle.
  - Load=1: OUT<=IN. SER_OUT unchanged.
  - Start=1, N>0: capture MODE and N, go to SHIFT, Busy<=1. No shift on this edge.
  - Start=1, N=0: stay IDLE, Done<=1 for one cycle, OUT unchanged.
  - Step=1: one shift per MODE; SER_OUT<=ejected bit.
  - None asserted: hold.
- Ejected bit: OUT[0] for modes 00/10; OUT[WIDTH-1] for modes 01/11. Rotates reinsert the ejected bit at the opposite end.
- SHIFT:
  - Each edge performs one shift using the captured mode (MODE changes are ignored). SER_IN is sampled live every cycle.
  - Count decrements on each shift. On the edge performing the Nth shift: FSM→IDLE, Busy<=0, Done<=1 for exactly one cycle.
  - Load, Start and Step are ignored while Busy=1.
- Timing: Start sampled at edge k with N>0 → shifts at edges k+1..k+N. Busy is high after edge k through edge k+N. Done is high for the cycle after edge k+N.
- A new Start may be accepted in the cycle Done is high; that FSM is in IDLE.
- Rotate bursts with N=WIDTH return the original value. N>WIDTH is legal and wraps naturally.
- Shift bursts with N>=WIDTH leave OUT filled entirely with sampled SER_IN values.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: adds output port PARITY (1 bit), registered, equal to XOR of the next OUT value. It updates on the same edge as OUT and resets to XOR of RESET_VAL.
- Undefined: no PARITY port and no parity logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, RESET_VAL=8'h00. Load=1, IN=8'hA5 → OUT=8'hA5 next cycle. Then RST_N=0 mid-cycle → OUT=8'h00, Busy=0 immediately, without a clock edge.
- OUT=8'hA5, Step with MODE=00, SER_IN=1 → OUT=8'hD2, SER_OUT=1. Then Step with MODE=01, SER_IN=0 → OUT=8'hA4, SER_OUT=1.
- OUT=8'h81, Start, MODE=10, Shift_Cnt=3 → Busy high for 3 cycles, OUT sequence C0,60,30, then Done pulse for 1 cycle with OUT=8'h30. Toggling MODE during the burst has no effect.
- OUT=8'h3C, Start, MODE=11, Shift_Cnt=8 → after 8 shifts OUT=8'h3C, Done=1 for one cycle. Load and Step asserted during Busy are ignored.
- Start with Shift_Cnt=0 → Done=1 the next cycle, Busy never high, OUT unchanged. Load and Start asserted together in IDLE → load wins, no burst.
- RST_N asserted at cycle 2 of a 5-shift burst → OUT=RESET_VAL, Busy=0, no Done. After release, a fresh Start with Shift_Cnt=2 completes normally. With USR_PARITY_EN, PARITY tracks XOR(OUT) every cycle.
